dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Memory-stage access controller between the EX/MEM pipeline register and a stalling data memory (Stall/Done handshake). It captures one load/store request per access, holds it at the memory until the access completes, and delivers read data to the MEM/WB boundary. While an access is in flight it raises a pipeline stall. It flags misaligned addresses and memory timeouts as sticky errors.

## Interface
Parameters:
- MAX_WAIT, default 31: maximum WAIT cycles without mem_done before a timeout error; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX/MEM holds a memory operation.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  16  byte address (ALU result).
- req_wdata  in  16  store data.
- req_dump  in  1  request memory dump (halt); rides with the request.
- wb_ready  in  1  MEM/WB can accept the response this cycle.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  latched address.
- mem_wdata  out  16  latched store data.
- mem_dump  out  1  createdump strobe.
- mem_stall  in  1  memory refuses the strobe this cycle.
- mem_done  in  1  access complete; mem_rdata is valid this cycle.
- mem_rdata  in  16  read data.
- resp_valid  out  1  response available to MEM/WB.
- resp_rdata  out  16  load data; 0x0000 for stores.
- pipe_stall  out  1  freeze IF/ID/EX and EX/MEM.
- align_err  out  1  sticky misaligned-access error.
- timeout_err  out  1  sticky memory-timeout error.

## Operation
The controller has five states: IDLE, REQ, WAIT, RESP and ERR.

- **IDLE:**
  - req_valid=1 and req_addr[0]=1 -> ERR, align_err<=1.
  - req_valid=1 and req_addr[0]=0 -> REQ. Latch addr, wdata, write and dump; clear the wait counter.
- **REQ:**
  - mem_enable=1, mem_wr=latched write, mem_dump=latched dump.
  - mem_stall=1 -> stay in REQ; re-present the strobe next cycle.
  - mem_stall=0 and mem_done=1 -> RESP. Latch rdata (loads) or 0x0000 (stores).
  - mem_stall=0 and mem_done=0 -> WAIT.
- **WAIT:**
  - Strobes are low.
  - mem_done=1 -> RESP and latch data as in REQ.
  - Otherwise counter+1. Reaching MAX_WAIT -> ERR, timeout_err<=1.
- **RESP:**
  - resp_valid=1 and resp_rdata is held stable.
  - wb_ready=1 -> IDLE.
  - wb_ready=0 -> hold RESP and the data.
- **ERR:**
  - Terminal until reset.
  - Strobes are low, pipe_stall=1, resp_valid=0.

Output and signal rules:
- pipe_stall = (IDLE & req_valid) | REQ | WAIT | (RESP & ~wb_ready) | ERR.
- mem_addr and mem_wdata hold their latched values in every state; only enable/wr/dump are gated.
- mem_done outside REQ or WAIT is ignored.
- Dump-only requests (req_dump=1) follow the same alignment and handshake rules.
- The wait counter is $clog2(MAX_WAIT+1) bits wide and saturates at MAX_WAIT.
- align_err takes priority: a misaligned request never asserts mem_enable.

## Timing
Reset values:
- rst low forces IDLE immediately (asynchronous).
- All outputs go to 0: mem_* strobes, mem_addr, mem_wdata, resp_valid, resp_rdata, pipe_stall, align_err, timeout_err.
- Counter = 0.
- Reset asserted mid-access abandons the access. No strobe is issued after rst falls.

Latency:
- Request accepted at edge N (IDLE, req_valid) -> strobe visible in cycle N+1.
- Zero-wait memory: mem_done in the REQ cycle -> resp_valid in cycle N+2.
- The total stall count for an access is 2 + mem_stall cycles + WAIT cycles + wb backpressure cycles.
- Back-to-back requests: a new req_valid is sampled in the first IDLE cycle after RESP. The minimum issue interval is 3 cycles.

Boundary cases:
- mem_stall and mem_done both high in REQ -> stall wins; stay in REQ.
- Timeout fires when the counter equals MAX_WAIT at the edge. If mem_done arrives in that same cycle, done wins -> RESP.
- wb_ready is ignored in every state except RESP.

## Test plan
- **Aligned load, 0-wait:**
  - Stimulus: req addr 0x0010, mem_done in the REQ cycle with rdata 0xBEEF, wb_ready=1.
  - Required: mem_enable high for 1 cycle, mem_wr=0; resp_rdata=0xBEEF, resp_valid one cycle later; pipe_stall high for 2 cycles.
- **Store with memory stall:**
  - Stimulus: addr 0x0042, wdata 0x1234, mem_stall high 2 cycles, then done after 3 WAIT cycles.
  - Required: mem_enable/mem_wr high 3 cycles; resp_rdata=0x0000; no timeout.
- **Misaligned access:**
  - Stimulus: req_addr 0x0007.
  - Required: mem_enable never asserts; align_err=1 next cycle and stays high; pipe_stall stays 1 until rst.
- **Timeout with MAX_WAIT=4:**
  - Stimulus: mem_done never asserted.
  - Required: timeout_err=1 after 4 WAIT cycles; a coincident-done variant ends in RESP with no error.
- **Backpressure:**
  - Stimulus: load returns 0x00FF, wb_ready low 3 cycles.
  - Required: resp_valid and resp_rdata=0x00FF held 4 cycles; IDLE after wb_ready rises.
- **Reset mid-WAIT:**
  - Stimulus: rst low during WAIT.
  - Required: all outputs 0 immediately, including the sticky errors; next request proceeds normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Memory-stage access controller for a stalling data memory.
// Holds one load/store at the memory and returns read data to MEM/WB.
module dmem_access_ctrl #(
   parameter int MAX_WAIT = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic        req_dump,
   input  logic        wb_ready,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_dump,
   input  logic        mem_stall,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        pipe_stall,
   output logic        align_err,
   output logic        timeout_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic write_q, write_d;
   logic dump_q, dump_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic align_q, align_d;
   logic tmo_q, tmo_d;

   // State register and latched request/response fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         write_q <= 1'b0;
         dump_q  <= 1'b0;
         cnt_q   <= '0;
         align_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         write_q <= write_d;
         dump_q  <= dump_d;
         cnt_q   <= cnt_d;
         align_q <= align_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic; stores return zero, done beats the timeout
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      write_d = write_q;
      dump_d  = dump_q;
      cnt_d   = cnt_q;
      align_d = align_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_addr[0]) begin
                  state_d = S_ERR;
                  align_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  write_d = req_write;
                  dump_d  = req_dump;
                  cnt_d   = '0;
               end
            end
         end
         S_REQ: begin
            if (!mem_stall) begin
               if (mem_done) begin
                  state_d = S_RESP;
                  rdata_d = write_q ? 16'h0000 : mem_rdata;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_done) begin
               state_d = S_RESP;
               rdata_d = write_q ? 16'h0000 : mem_rdata;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if (cnt_q >= CNT_LAST) begin
                  state_d = S_ERR;
                  tmo_d   = 1'b1;
               end
            end
         end
         S_RESP: begin
            if (wb_ready) begin
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes only in REQ; address/data always reflect the latch
   always_comb begin
      mem_enable  = (state_q == S_REQ);
      mem_wr      = (state_q == S_REQ) & write_q;
      mem_dump    = (state_q == S_REQ) & dump_q;
      mem_addr    = addr_q;
      mem_wdata   = wdata_q;
      resp_valid  = (state_q == S_RESP);
      resp_rdata  = rdata_q;
      align_err   = align_q;
      timeout_err = tmo_q;
      pipe_stall  = rst & (((state_q == S_IDLE) & req_valid) |
                           (state_q == S_REQ) |
                           (state_q == S_WAIT) |
                           ((state_q == S_RESP) & ~wb_ready) |
                           (state_q == S_ERR));
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with MAX_WAIT=4.
// Each step drives inputs after the edge and checks mid-cycle.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_dump;
   logic        wb_ready;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_dump;
   logic        mem_stall;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        pipe_stall;
   logic        align_err;
   logic        timeout_err;
   logic [6:0]  ctl;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.MAX_WAIT(4)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_dump(req_dump),
      .wb_ready(wb_ready),
      .mem_enable(mem_enable),
      .mem_wr(mem_wr),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_dump(mem_dump),
      .mem_stall(mem_stall),
      .mem_done(mem_done),
      .mem_rdata(mem_rdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .pipe_stall(pipe_stall),
      .align_err(align_err),
      .timeout_err(timeout_err)
   );

   // {en, wr, dump, resp_valid, pipe_stall, align_err, timeout_err}
   assign ctl = {mem_enable, mem_wr, mem_dump, resp_valid,
                 pipe_stall, align_err, timeout_err};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_c(input string tag, input logic [6:0] exp);
      #1;
      n_vec++;
      assert (ctl === exp) else begin
         n_err++;
         $error("FAIL %s: ctl observed %b expected %b", tag, ctl, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 16'h0000;
      req_dump  = 1'b0;
      wb_ready  = 1'b0;
      mem_stall = 1'b0;
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;

      // Reset state
      #2;
      chk_c("reset_ctl", 7'b0000000);
      chk_d("reset_addr", mem_addr, 16'h0000);
      chk_d("reset_rdata", resp_rdata, 16'h0000);
      tick();
      tick();
      rst = 1'b1;

      // Aligned load, zero wait
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
      wb_ready = 1'b1;
      chk_c("ld_idle", 7'b0000100);
      tick();
      req_valid = 1'b0; mem_done = 1'b1; mem_rdata = 16'hBEEF;
      chk_c("ld_req", 7'b1000100);
      chk_d("ld_addr", mem_addr, 16'h0010);
      tick();
      mem_done = 1'b0; mem_rdata = 16'h0000;
      chk_c("ld_resp", 7'b0001000);
      chk_d("ld_rdata", resp_rdata, 16'hBEEF);
      tick();
      chk_c("ld_done", 7'b0000000);

      // Stray done in IDLE is ignored
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk_c("idle_done", 7'b0000000);

      // Store with two stall cycles and three WAIT cycles
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0042;
      req_wdata = 16'h1234;
      tick();
      req_valid = 1'b0; req_write = 1'b0; req_wdata = 16'h0000;
      mem_stall = 1'b1; mem_done = 1'b1;
      chk_c("st_req1", 7'b1100100);
      chk_d("st_wdata", mem_wdata, 16'h1234);
      tick();
      mem_done = 1'b0;
      chk_c("st_req2", 7'b1100100);
      tick();
      mem_stall = 1'b0;
      chk_c("st_req3", 7'b1100100);
      tick();
      chk_c("st_wait1", 7'b0000100);
      tick();
      chk_c("st_wait2", 7'b0000100);
      tick();
      mem_done = 1'b1; mem_rdata = 16'hAAAA;
      chk_c("st_wait3", 7'b0000100);
      tick();
      mem_done = 1'b0;
      chk_c("st_resp", 7'b0001000);
      chk_d("st_rdata", resp_rdata, 16'h0000);
      tick();
      chk_c("st_done", 7'b0000000);

      // Backpressure: load 0x00FF, wb_ready low 3 cycles
      req_valid = 1'b1; req_addr = 16'h0020;
      tick();
      req_valid = 1'b0; mem_done = 1'b1; mem_rdata = 16'h00FF;
      wb_ready = 1'b0;
      chk_c("bp_req", 7'b1000100);
      tick();
      mem_done = 1'b0; mem_rdata = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         chk_c("bp_hold", 7'b0001100);
         chk_d("bp_hold_data", resp_rdata, 16'h00FF);
         tick();
      end
      wb_ready = 1'b1;
      chk_c("bp_release", 7'b0001000);
      chk_d("bp_release_data", resp_rdata, 16'h00FF);
      tick();
      chk_c("bp_idle", 7'b0000000);

      // Done coincides with the would-be timeout cycle
      req_valid = 1'b1; req_addr = 16'h0030;
      tick();
      req_valid = 1'b0;
      chk_c("cd_req", 7'b1000100);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk_c("cd_wait", 7'b0000100);
         tick();
      end
      mem_done = 1'b1; mem_rdata = 16'h5A5A;
      chk_c("cd_wait4", 7'b0000100);
      tick();
      mem_done = 1'b0;
      chk_c("cd_resp", 7'b0001000);
      chk_d("cd_rdata", resp_rdata, 16'h5A5A);
      tick();
      chk_c("cd_idle", 7'b0000000);

      // Timeout: four WAIT cycles without done
      req_valid = 1'b1; req_addr = 16'h0040;
      tick();
      req_valid = 1'b0;
      chk_c("to_req", 7'b1000100);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_c("to_wait", 7'b0000100);
         tick();
      end
      chk_c("to_err", 7'b0000101);
      mem_done = 1'b1; wb_ready = 1'b1;
      tick();
      mem_done = 1'b0;
      chk_c("to_sticky", 7'b0000101);
      rst = 1'b0;
      chk_c("to_reset", 7'b0000000);
      tick();
      rst = 1'b1;

      // Reset mid-WAIT
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0050;
      req_wdata = 16'hCAFE;
      tick();
      req_valid = 1'b0; req_write = 1'b0;
      chk_c("rw_req", 7'b1100100);
      tick();
      chk_c("rw_wait", 7'b0000100);
      rst = 1'b0;
      chk_c("rw_reset", 7'b0000000);
      chk_d("rw_addr", mem_addr, 16'h0000);
      chk_d("rw_wdata", mem_wdata, 16'h0000);
      chk_d("rw_rdata", resp_rdata, 16'h0000);
      tick();
      rst = 1'b1;

      // Next request after reset, carrying a dump
      req_valid = 1'b1; req_addr = 16'h0060; req_dump = 1'b1;
      tick();
      req_valid = 1'b0; req_dump = 1'b0;
      mem_done = 1'b1; mem_rdata = 16'h7777;
      chk_c("dp_req", 7'b1010100);
      chk_d("dp_addr", mem_addr, 16'h0060);
      tick();
      mem_done = 1'b0;
      chk_c("dp_resp", 7'b0001000);
      chk_d("dp_rdata", resp_rdata, 16'h7777);
      tick();

      // Misaligned dump request
      req_valid = 1'b1; req_addr = 16'h0007; req_dump = 1'b1;
      chk_c("ma_idle", 7'b0000100);
      tick();
      req_valid = 1'b0; req_dump = 1'b0;
      chk_c("ma_err", 7'b0000110);
      chk_d("ma_addr", mem_addr, 16'h0060);
      for (int i = 0; i < 3; i++) begin
         mem_done = 1'b1;
         tick();
         mem_done = 1'b0;
         chk_c("ma_sticky", 7'b0000110);
      end
      rst = 1'b0;
      chk_c("ma_reset", 7'b0000000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
